// File: rtl/apb_uart_pkg.sv
// ============================================================================
// apb_uart_pkg : register map, bit indices and FSM encodings for apb_uart_lite
// Revision 1.0
// ============================================================================
`default_nettype none

package apb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_BUSY    = 5;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_LOOPBACK  = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_uart_fifo.sv
// ============================================================================
// apb_uart_fifo : synchronous FIFO, power-of-two depth, push/pop legal when full
// Revision 1.0
// ============================================================================
`default_nettype none

module apb_uart_fifo #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [P_WIDTH-1:0] din,
    output logic [P_WIDTH-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (AW+1)'(P_DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/apb_uart_lite.sv
// ============================================================================
// apb_uart_lite : APB2 UART with TX FIFO, single RX holding register, RX IRQ.
// Optional macro APB_UART_LOOPBACK_EN enables internal TX->RX loopback (CTRL[3]).
// Revision 1.0
// ============================================================================
`default_nettype none

module apb_uart_lite #(
    parameter logic [15:0] P_ADDR_START = 16'h0000,
    parameter int          P_TX_DEPTH   = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        TXD,
    input  logic        RXD,
    output logic        IRQ
);

    import apb_uart_pkg::*;

    logic        hit, wr, rd, wr_data, rd_data, wr_status;
    logic [3:0]  ctrl;
    logic [15:0] div;
    logic [7:0]  rx_hold;
    logic        rx_valid, rx_overrun, frame_err, irq;
    logic [5:0]  status;
    logic        loopback;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        unused_bits;

    assign unused_bits = &{1'b0, PADDR[1:0], PWDATA[31:16]};

    assign hit       = (PADDR[31:4] == {16'h0000, P_ADDR_START[15:4]});
    assign wr        = PSEL & PENABLE & hit & PWRITE;
    assign rd        = PSEL & PENABLE & hit & ~PWRITE;
    assign wr_data   = wr & (PADDR[3:2] == REG_DATA);
    assign rd_data   = rd & (PADDR[3:2] == REG_DATA);
    assign wr_status = wr & (PADDR[3:2] == REG_STATUS);

`ifdef APB_UART_LOOPBACK_EN
    assign loopback = ctrl[CTRL_LOOPBACK];
`else
    assign loopback = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl <= '0;
            div  <= '0;
        end else if (wr) begin
            if (PADDR[3:2] == REG_CTRL) begin
`ifdef APB_UART_LOOPBACK_EN
                ctrl <= PWDATA[3:0];
`else
                ctrl <= {1'b0, PWDATA[2:0]};
`endif
            end
            if (PADDR[3:2] == REG_DIV) div <= PWDATA[15:0];
        end
    end

    // ---------------- TX path ----------------
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_pop, tx_tick, tx_line;

    apb_uart_fifo #(.P_DEPTH(P_TX_DEPTH), .P_WIDTH(8)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (wr_data),
        .pop   (tx_pop),
        .din   (PWDATA[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_tick = (tx_cnt == tx_div);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: if (ctrl[CTRL_TX_EN] && !fifo_empty) begin
                tx_next = TX_START;
                tx_pop  = 1'b1;
            end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP: if (tx_tick) begin
                if (ctrl[CTRL_TX_EN] && !fifo_empty) begin
                    tx_next = TX_START;
                    tx_pop  = 1'b1;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // The divisor is latched per bit so a DIV write only acts at the next bit boundary.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            if (tx_pop) begin
                tx_shift <= fifo_dout;
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
            if (tx_pop || tx_tick) begin
                tx_cnt <= '0;
                tx_div <= div;
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    assign tx_line = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    assign TXD     = loopback ? 1'b1 : tx_line;

    // ---------------- RX path ----------------
    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_fall, rx_half, rx_tick, rx_restart, rx_done;
    logic        frame_ok, frame_bad;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= loopback ? tx_line : RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_half = (rx_cnt == {1'b0, rx_div[15:1]});
    assign rx_tick = (rx_cnt == rx_div);

    always_comb begin
        rx_next    = rx_state;
        rx_restart = 1'b0;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: if (ctrl[CTRL_RX_EN] && rx_fall) begin
                rx_next    = RX_START;
                rx_restart = 1'b1;
            end
            RX_START: if (rx_half) begin
                rx_next    = rx_s2 ? RX_IDLE : RX_DATA;
                rx_restart = 1'b1;
            end
            RX_DATA: if (rx_tick) begin
                rx_restart = 1'b1;
                if (rx_bit == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_next = RX_IDLE;
                rx_done = 1'b1;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_restart) begin
                rx_cnt <= '0;
                rx_div <= div;
            end else if (rx_state != RX_IDLE) begin
                rx_cnt <= rx_cnt + 16'd1;
            end
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    assign frame_ok  = rx_done & rx_s2;
    assign frame_bad = rx_done & ~rx_s2;

    // A byte landing on the same cycle as a DATA read replaces the one being read.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_hold    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (frame_ok && (!rx_valid || rd_data)) begin
                rx_hold  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (frame_ok && rx_valid && !rd_data)      rx_overrun <= 1'b1;
            else if (wr_status && PWDATA[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (frame_bad)                              frame_err <= 1'b1;
            else if (wr_status && PWDATA[ST_FRAME_ERR]) frame_err <= 1'b0;
            irq <= rx_valid & ctrl[CTRL_RX_IRQ_EN];
        end
    end

    assign IRQ = irq;

    assign status = {(tx_state != TX_IDLE), frame_err, rx_overrun, rx_valid,
                     fifo_empty, fifo_full};

    always_comb begin
        PRDATA = '0;
        if (PSEL && hit) begin
            case (PADDR[3:2])
                REG_DATA:   PRDATA[7:0]  = rx_hold;
                REG_STATUS: PRDATA[5:0]  = status;
                REG_CTRL:   PRDATA[3:0]  = ctrl;
                REG_DIV:    PRDATA[15:0] = div;
                default:    PRDATA       = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/apb_uart_lite.md
APB_UART_LITE -- requirements
Module: apb_uart_lite

Interface
REQ-001 Parameter P_ADDR_START, default 16'h0000, base address; register window is 16 bytes.
REQ-002 Parameter P_TX_DEPTH, default 4, TX FIFO entries; power of two, 2..16.
REQ-003 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 PRESET  input  1  reset, asynchronous and active-high.
REQ-005 PSEL  input  1  APB select.
REQ-006 PADDR  input  32  APB address; PADDR[3:2] selects the register.
REQ-007 PENABLE  input  1  APB access phase.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PWDATA  input  32  write data.
REQ-010 PRDATA  output  32  read data; zero when PSEL=0 or the address is unmapped.
REQ-011 TXD  output  1  serial transmit; idles high.
REQ-012 RXD  input  1  serial receive; asynchronous to PCLK.
REQ-013 IRQ  output  1  registered receive interrupt.

Function
REQ-014 Bus: APB2 protocol, zero wait states, no PREADY/PSLVERR; side effects occur only on the access cycle (PSEL&PENABLE) when PADDR[31:4]==P_ADDR_START[15:4].
REQ-015 Register map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIV; all bits not listed read 0.
REQ-016 DATA write pushes PWDATA[7:0] into the TX FIFO; a push while the FIFO is full is dropped silently.
REQ-017 DATA read returns {24'h0, rx_hold} and clears RX_VALID on the access cycle; a read while RX_VALID=0 returns the stale byte.
REQ-018 STATUS bits: [0] TX_FULL, [1] TX_EMPTY, [2] RX_VALID, [3] RX_OVERRUN (sticky), [4] FRAME_ERR (sticky), [5] TX_BUSY; writing 1 to bit 3 or 4 clears that bit.
REQ-019 CTRL bits: [0] TX_EN, [1] RX_EN, [2] RX_IRQ_EN, [3] LOOPBACK (see Configuration).
REQ-020 DIV[15:0]: bit period = DIV+1 PCLK cycles.
REQ-021 TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state lasts one bit period.
REQ-022 TX leaves IDLE on the cycle after the FIFO becomes non-empty with TX_EN=1, popping one entry; back-to-back frames follow with no idle bit.
REQ-023 Clearing TX_EN mid-frame completes the current frame, then holds IDLE.
REQ-024 A simultaneous FIFO push and pop is legal in every state, including full.
REQ-025 RX path: RXD passes through a 2-flop synchronizer.
REQ-026 RX FSM: IDLE -> START on a falling edge with RX_EN=1; START samples at DIV>>1 and returns to IDLE if the line is high (glitch); DATA samples each bit one period later; STOP samples the stop bit.
REQ-027 Stop bit low: set FRAME_ERR and discard the byte.
REQ-028 Stop bit high and RX_VALID=0: load rx_hold and set RX_VALID.
REQ-029 Stop bit high and RX_VALID=1: set RX_OVERRUN and keep the old byte.
REQ-030 If a DATA read and a frame completion occur in the same cycle, the new byte loads and RX_VALID stays 1.
REQ-031 IRQ is registered: 1 cycle after RX_VALID & RX_IRQ_EN become true.
REQ-032 A DIV write mid-frame takes effect at the next bit boundary.

Reset
REQ-033 On PRESET=1, immediately: TXD=1, IRQ=0, both FSMs IDLE, FIFO empty, RX_VALID/RX_OVERRUN/FRAME_ERR=0, CTRL=0, DIV=16'h0000, rx_hold=0, synchronizer flops=1.
REQ-034 Reset mid-frame aborts the frame; TXD returns high with no partial stop bit.

Configuration
REQ-035 Macro APB_UART_LOOPBACK_EN: when defined, CTRL[3]=1 internally feeds TXD into the RX synchronizer input, and TXD is held high.
REQ-036 Without the macro, CTRL[3] is read-only 0 and RXD is always the RX source.

Structure
REQ-037 Shared package apb_uart_pkg holds: register offsets, STATUS/CTRL bit indices, TX/RX FSM state encodings.
REQ-038 One sub-module, apb_uart_fifo: synchronous FIFO with push, pop, full and empty, parameterized by P_TX_DEPTH.

Verification
REQ-039 Reset, then read all four registers -> STATUS=0x02, CTRL=0, DIV=0, DATA=0; TXD=1.
REQ-040 DIV=3, CTRL=0x1, write DATA 0x41 -> TXD: low 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), then high 4 cycles.
REQ-041 DIV=3, CTRL=0x7; drive RXD with frame 0x5A -> RX_VALID=1, IRQ=1 one cycle later; DATA read returns 0x5A; RX_VALID=0.
REQ-042 Two RX frames with no read between them -> DATA=first byte, RX_OVERRUN=1; write STATUS 0x08 -> RX_OVERRUN=0.
REQ-043 Frame with stop bit low -> FRAME_ERR=1, RX_VALID=0; 5 DATA writes with TX_EN=0 and depth 4 -> TX_FULL=1, 5th byte lost.
REQ-044 With APB_UART_LOOPBACK_EN and CTRL=0xB, send 'A'..'Z' -> each byte received matches, zero errors.
